// File: rtl/wconv_pkg.sv
// Shared types and sizing helpers for the stream width converter.
package wconv_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    FLUSH = 1'b1
  } state_e;

  localparam int STAT_BEAT_W  = 32;
  localparam int STAT_WORD_W  = 32;
  localparam int STAT_FRAME_W = 16;

  // Fill counter must represent 0..cap inclusive.
  function automatic int cnt_width(input int cap);
    return $clog2(cap + 1);
  endfunction

endpackage

// File: rtl/wconv_stats.sv
// Traffic counters for the width converter; only built with WCONV_STATS_EN.
module wconv_stats
  import wconv_pkg::*;
(
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    clr,
  input  logic                    in_fire,
  input  logic                    out_fire,
  input  logic                    out_last,
  output logic [STAT_BEAT_W-1:0]  in_beats,
  output logic [STAT_WORD_W-1:0]  out_words,
  output logic [STAT_FRAME_W-1:0] frames
);

  // Clear wins over increment; counters wrap naturally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_beats  <= '0;
      out_words <= '0;
      frames    <= '0;
    end else if (clr) begin
      in_beats  <= '0;
      out_words <= '0;
      frames    <= '0;
    end else begin
      if (in_fire)             in_beats  <= in_beats  + STAT_BEAT_W'(1);
      if (out_fire)            out_words <= out_words + STAT_WORD_W'(1);
      if (out_fire && out_last) frames   <= frames    + STAT_FRAME_W'(1);
    end
  end

endmodule

// File: rtl/stream_width_converter.sv
// LSB-first IN_W -> OUT_W stream repacker with frame flush and zero padding.
// Optional traffic counters under WCONV_STATS_EN.
module stream_width_converter
  import wconv_pkg::*;
#(
  parameter int IN_W  = 256,
  parameter int OUT_W = 324
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready
`ifdef WCONV_STATS_EN
  ,
  input  logic                    stat_clr,
  output logic [STAT_BEAT_W-1:0]  stat_in_beats,
  output logic [STAT_WORD_W-1:0]  stat_out_words,
  output logic [STAT_FRAME_W-1:0] stat_frames
`endif
);

  localparam int CAP   = IN_W + OUT_W;
  localparam int CNT_W = cnt_width(CAP);
  localparam logic [CNT_W-1:0] IN_C  = CNT_W'(IN_W);
  localparam logic [CNT_W-1:0] OUT_C = CNT_W'(OUT_W);

  state_e           state_q;
  logic [CAP-1:0]   buf_q, buf_sh, buf_nx;
  logic [CNT_W-1:0] cnt_q, cnt_sh, cnt_nx;
  logic             in_fire, out_fire;

  assign in_ready  = (state_q == FILL) && (cnt_q <= OUT_C);
  assign out_valid = (cnt_q >= OUT_C) || ((state_q == FLUSH) && (cnt_q != '0));
  assign out_last  = (state_q == FLUSH) && (cnt_q <= OUT_C) && (cnt_q != '0);
  assign out_data  = buf_q[OUT_W-1:0];

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Drain first, then append the new beat at the post-drain fill level.
  always_comb begin
    buf_sh = buf_q;
    cnt_sh = cnt_q;
    if (out_fire) begin
      buf_sh = buf_q >> OUT_W;
      cnt_sh = (cnt_q > OUT_C) ? cnt_q - OUT_C : '0;
    end
    buf_nx = buf_sh;
    cnt_nx = cnt_sh;
    if (in_fire) begin
      buf_nx = buf_sh | (CAP'(in_data) << cnt_sh);
      cnt_nx = cnt_sh + IN_C;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= FILL;
      buf_q   <= '0;
      cnt_q   <= '0;
    end else begin
      buf_q <= buf_nx;
      cnt_q <= cnt_nx;
      case (state_q)
        FILL:  if (in_fire && in_last) state_q <= FLUSH;
        FLUSH: if (out_fire && out_last) begin
          state_q <= FILL;
          buf_q   <= '0;
          cnt_q   <= '0;
        end
        default: state_q <= FILL;
      endcase
    end
  end

`ifdef WCONV_STATS_EN
  wconv_stats u_stats (
    .clk       (clk),
    .rstn      (rstn),
    .clr       (stat_clr),
    .in_fire   (in_fire),
    .out_fire  (out_fire),
    .out_last  (out_last),
    .in_beats  (stat_in_beats),
    .out_words (stat_out_words),
    .frames    (stat_frames)
  );
`endif

endmodule

// File: tb/tb_stream_width_converter.sv
// Scoreboard bench: 256->324 instance plus a 64->24 instance.
module tb_stream_width_converter;
  import wconv_pkg::*;

  localparam int SW = 82 * 256 + 324;

  typedef struct packed { logic [323:0] d; logic l; } exp_t;
  typedef struct packed { logic [23:0]  d; logic l; } expb_t;

  logic clk = 0;
  logic rstn;
  always #5 clk = ~clk;

  logic [255:0] a_in_data;
  logic         a_in_valid, a_in_last, a_in_ready;
  logic [323:0] a_out_data;
  logic         a_out_valid, a_out_last, a_out_ready;

  logic [63:0]  b_in_data;
  logic         b_in_valid, b_in_last, b_in_ready;
  logic [23:0]  b_out_data;
  logic         b_out_valid, b_out_last, b_out_ready;

`ifdef WCONV_STATS_EN
  logic                    stat_clr, b_stat_clr;
  logic [STAT_BEAT_W-1:0]  stat_in_beats, b_stat_in_beats;
  logic [STAT_WORD_W-1:0]  stat_out_words, b_stat_out_words;
  logic [STAT_FRAME_W-1:0] stat_frames, b_stat_frames;
`endif

  stream_width_converter #(.IN_W(256), .OUT_W(324)) dut_a (
    .clk(clk), .rstn(rstn),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_last(a_in_last), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_last(a_out_last), .out_ready(a_out_ready)
`ifdef WCONV_STATS_EN
    , .stat_clr(stat_clr), .stat_in_beats(stat_in_beats),
    .stat_out_words(stat_out_words), .stat_frames(stat_frames)
`endif
  );

  stream_width_converter #(.IN_W(64), .OUT_W(24)) dut_b (
    .clk(clk), .rstn(rstn),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_last(b_in_last), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_last(b_out_last), .out_ready(b_out_ready)
`ifdef WCONV_STATS_EN
    , .stat_clr(b_stat_clr), .stat_in_beats(b_stat_in_beats),
    .stat_out_words(b_stat_out_words), .stat_frames(b_stat_frames)
`endif
  );

  int    checks = 0;
  int    errors = 0;
  exp_t  expq[$];
  expb_t expb[$];
  logic [SW-1:0] stream;
  bit    ignore_a = 0;
  int    rdy_mode = 0;

  task automatic check(input bit ok, input string name, input string detail);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  // out_ready pattern: 0 -> always 1, 1 -> high one cycle in three
  initial begin
    int ph;
    ph = 0;
    a_out_ready = 1;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 1) a_out_ready = (ph == 0);
      else               a_out_ready = 1;
      ph = (ph + 1) % 3;
    end
  end

  // Monitor A: scoreboard, stall stability, fill-level handshake model
  int           m_cnt;
  bit           m_flush;
  bit           st_vld;
  logic [323:0] st_data;
  always @(negedge clk) begin
    if (!rstn) begin
      m_cnt = 0; m_flush = 0; st_vld = 0;
    end else begin
      bit   exp_rdy, exp_vld, of, inf;
      exp_t e;
      if (st_vld)
        check(a_out_valid && a_out_data == st_data, "a_stall_hold",
              $sformatf("valid=%0b data=%h want valid=1 data=%h", a_out_valid, a_out_data, st_data));
      exp_rdy = !m_flush && (m_cnt <= 324);
      exp_vld = (m_cnt >= 324) || (m_flush && m_cnt > 0);
      check(a_in_ready == exp_rdy, "a_in_ready",
            $sformatf("got %0b want %0b (bits %0d)", a_in_ready, exp_rdy, m_cnt));
      check(a_out_valid == exp_vld, "a_out_valid",
            $sformatf("got %0b want %0b (bits %0d)", a_out_valid, exp_vld, m_cnt));
      of  = a_out_valid && a_out_ready;
      inf = a_in_valid && a_in_ready;
      if (of && !ignore_a) begin
        if (expq.size() == 0) check(0, "a_extra_word", $sformatf("got %h with none expected", a_out_data));
        else begin
          e = expq.pop_front();
          check(a_out_data == e.d && a_out_last == e.l, "a_word",
                $sformatf("got %h last=%0b want %h last=%0b", a_out_data, a_out_last, e.d, e.l));
        end
      end
      st_vld  = a_out_valid && !a_out_ready;
      st_data = a_out_data;
      if (of) begin
        if (m_flush && m_cnt <= 324) begin m_cnt = 0; m_flush = 0; end
        else m_cnt = (m_cnt > 324) ? m_cnt - 324 : 0;
      end
      if (inf) begin
        m_cnt += 256;
        if (a_in_last) m_flush = 1;
      end
    end
  end

  // Monitor B
  always @(negedge clk) begin
    if (rstn && b_out_valid) begin
      expb_t e;
      check(b_in_ready == 0, "b_in_ready_low", $sformatf("got %0b want 0", b_in_ready));
      if (b_out_ready) begin
        if (expb.size() == 0) check(0, "b_extra_word", $sformatf("got %h with none expected", b_out_data));
        else begin
          e = expb.pop_front();
          check(b_out_data == e.d && b_out_last == e.l, "b_word",
                $sformatf("got %h last=%0b want %h last=%0b", b_out_data, b_out_last, e.d, e.l));
        end
      end
    end
  end

  task automatic send_beat(input logic [255:0] d, input bit last);
    int t;
    t = 0;
    a_in_data = d; a_in_valid = 1; a_in_last = last;
    forever begin
      @(negedge clk);
      if (a_in_ready) break;
      if (++t > 500) begin check(0, "a_in_timeout", "in_ready never rose"); break; end
    end
    @(posedge clk); #1;
    a_in_valid = 0; a_in_last = 0;
  endtask

  // Expected words from a flat LSB-first bit stream of the whole frame.
  task automatic send_frame(input int n, input int base, input bit alt);
    int   nw;
    exp_t e;
    stream = '0;
    for (int i = 0; i < n; i++) stream[i*256 +: 256] = 256'(base) + 256'(i);
    nw = (n * 256 + 323) / 324;
    for (int k = 0; k < nw; k++) begin
      e.d = stream[k*324 +: 324];
      e.l = (k == nw - 1);
      expq.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      send_beat(256'(base) + 256'(i), i == n - 1);
      if (alt) begin
        if (i == 0) check(a_out_valid == 0, "lat_beat1", $sformatf("valid=%0b want 0", a_out_valid));
        if (i == 1) check(a_out_valid == 1, "lat_beat2", $sformatf("valid=%0b want 1", a_out_valid));
        a_in_data = '1;
        @(posedge clk); #1;
      end
    end
    wait_a_drain();
  endtask

  task automatic wait_a_drain();
    int t;
    t = 0;
    while (expq.size() != 0 && t < 3000) begin @(negedge clk); t++; end
    check(expq.size() == 0, "a_drain", $sformatf("%0d words still expected", expq.size()));
    repeat (2) @(posedge clk);
    #1;
    check(a_out_valid == 0 && a_in_ready == 1, "a_idle",
          $sformatf("valid=%0b ready=%0b want valid=0 ready=1", a_out_valid, a_in_ready));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    expb_t eb;
    int    t;
    rstn = 0;
    a_in_data = '0; a_in_valid = 0; a_in_last = 0;
    b_in_data = '0; b_in_valid = 0; b_in_last = 0; b_out_ready = 1;
`ifdef WCONV_STATS_EN
    stat_clr = 0; b_stat_clr = 0;
`endif
    repeat (3) @(posedge clk);
    #1 rstn = 1;

    check(a_in_ready == 1 && a_out_valid == 0 && a_out_last == 0, "a_reset",
          $sformatf("rdy=%0b vld=%0b last=%0b want 1/0/0", a_in_ready, a_out_valid, a_out_last));
    check(b_in_ready == 1 && b_out_valid == 0 && b_out_last == 0, "b_reset",
          $sformatf("rdy=%0b vld=%0b last=%0b want 1/0/0", b_in_ready, b_out_valid, b_out_last));

    // 64->24: one all-ones beat gives two full words and a padded last
    eb.d = 24'hFFFFFF; eb.l = 0; expb.push_back(eb);
    eb.d = 24'hFFFFFF; eb.l = 0; expb.push_back(eb);
    eb.d = 24'h00FFFF; eb.l = 1; expb.push_back(eb);
    b_in_data = 64'hFFFF_FFFF_FFFF_FFFF; b_in_valid = 1; b_in_last = 1;
    @(posedge clk); #1;
    b_in_valid = 0; b_in_last = 0; b_in_data = '0;
    t = 0;
    while (expb.size() != 0 && t < 100) begin @(negedge clk); t++; end
    check(expb.size() == 0, "b_drain", $sformatf("%0d words still expected", expb.size()));
    @(posedge clk); #1;
    check(b_in_ready == 1 && b_out_valid == 0, "b_idle",
          $sformatf("rdy=%0b vld=%0b want 1/0", b_in_ready, b_out_valid));

    send_frame(1, 32'h1234, 0);
    send_frame(81, 1, 0);
    send_frame(3, 1, 1);
    rdy_mode = 1;
    send_frame(10, 100, 0);
    rdy_mode = 0;
    @(posedge clk); #1;

    // Abort a frame mid-way with reset
    ignore_a = 1;
    send_beat(256'd1, 0);
    send_beat(256'd2, 0);
    send_beat(256'd3, 0);
    check(a_out_valid == 1, "pre_reset_valid", $sformatf("valid=%0b want 1", a_out_valid));
    rstn = 0;
    #1;
    check(a_out_valid == 0 && a_out_last == 0 && a_in_ready == 1, "mid_reset",
          $sformatf("vld=%0b last=%0b rdy=%0b want 0/0/1", a_out_valid, a_out_last, a_in_ready));
    repeat (2) @(posedge clk);
    #1 rstn = 1;
    ignore_a = 0;
    expq.delete();
`ifdef WCONV_STATS_EN
    check(stat_in_beats == 0 && stat_out_words == 0 && stat_frames == 0, "stats_reset",
          $sformatf("got %0d/%0d/%0d want 0/0/0", stat_in_beats, stat_out_words, stat_frames));
`endif
    send_frame(1, 32'hABCD, 0);
`ifdef WCONV_STATS_EN
    check(stat_in_beats == 1 && stat_out_words == 1 && stat_frames == 1, "stats_frame",
          $sformatf("got %0d/%0d/%0d want 1/1/1", stat_in_beats, stat_out_words, stat_frames));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
